uart_phy: RTL and testbench

8N1 UART physical layer with independent receive and transmit paths sharing one clock and reset. Parameterised by an integer clocks-per-bit divisor. Converts between a serial line and byte-wide valid-strobed interfaces. Sits directly under the application-level protocol logic (e.g. a command/response FSM) and drives the board-level serial pins.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_bit_timer.sv | 41 ++++
 rtl/uart_phy.sv | 208 ++++++++++++++++++++
 tb/tb_uart_phy.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the 8N1 UART physical layer.
package uart_pkg;

   localparam int unsigned DATA_BITS = 8;
   localparam logic        START_BIT = 1'b0;
   localparam logic        STOP_BIT  = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit cycle counter. It runs while enabled and is cleared whenever it is
// disabled. It wraps at CLKS_PER_BIT-1 and raises one strobe at a
// configurable mid-bit count and another at the end of each bit.
module uart_bit_timer #(
   parameter int unsigned CLKS_PER_BIT = 2,
   parameter int unsigned MID_CNT      = CLKS_PER_BIT / 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   output logic o_mid,
   output logic o_end
);

   localparam int unsigned   CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] MID_VAL  = CW'(MID_CNT);

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count: advance while enabled, wrap at the last cycle of a bit, clear when idle
   always_comb begin
      cnt_d = '0;
      if (i_en && (cnt_q != LAST_CNT)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_mid = i_en & (cnt_q == MID_VAL);
   assign o_end = i_en & (cnt_q == LAST_CNT);

endmodule

// File: rtl/uart_phy.sv
// 8N1 UART physical layer: independent transmit and receive paths sharing
// one clock and reset, each timed by its own uart_bit_timer.
module uart_phy
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_rx_data,
   output logic       o_rx_valid,
   output logic       o_rx_busy,
   output logic [7:0] o_rx_data,
   input  logic [7:0] i_tx_data,
   input  logic       i_tx_valid,
   output logic       o_tx_busy,
   output logic       o_tx_data
);

   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   // ---------------------------------------------------------------- TX path
   uart_state_e          tx_state_q, tx_state_d;
   logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
   logic [2:0]           tx_idx_q,   tx_idx_d;
   logic                 tx_line_q,  tx_line_d;
   logic                 tx_mid, tx_end;

   uart_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .MID_CNT      (CLKS_PER_BIT / 2)
   ) u_tx_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (tx_state_q != IDLE),
      .o_mid (tx_mid),
      .o_end (tx_end)
   );

   // TX next state: accept in IDLE, then shift the frame out one bit per timer period
   always_comb begin
      tx_state_d = tx_state_q;
      tx_shift_d = tx_shift_q;
      tx_idx_d   = tx_idx_q;
      tx_line_d  = tx_line_q;
      case (tx_state_q)
         IDLE: begin
            if (i_tx_valid) begin
               tx_state_d = START;
               tx_line_d  = START_BIT;
               tx_shift_d = i_tx_data;
               tx_idx_d   = '0;
            end
         end
         START: begin
            if (tx_end) begin
               tx_state_d = DATA;
               tx_line_d  = tx_shift_q[0];
               tx_shift_d = tx_shift_q >> 1;
            end
         end
         DATA: begin
            if (tx_end) begin
               if (tx_idx_q == LAST_BIT) begin
                  tx_state_d = STOP;
                  tx_line_d  = STOP_BIT;
               end else begin
                  tx_idx_d   = tx_idx_q + 3'd1;
                  tx_line_d  = tx_shift_q[0];
                  tx_shift_d = tx_shift_q >> 1;
               end
            end
         end
         STOP: begin
            if (tx_end) begin
               tx_state_d = IDLE;
               tx_line_d  = STOP_BIT;
            end
         end
         default: begin
            tx_state_d = IDLE;
            tx_line_d  = STOP_BIT;
         end
      endcase
   end

   // TX state and registered serial line
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_q <= IDLE;
         tx_shift_q <= '0;
         tx_idx_q   <= '0;
         tx_line_q  <= STOP_BIT;
      end else begin
         tx_state_q <= tx_state_d;
         tx_shift_q <= tx_shift_d;
         tx_idx_q   <= tx_idx_d;
         tx_line_q  <= tx_line_d;
      end
   end

   assign o_tx_data = tx_line_q;
   assign o_tx_busy = (tx_state_q != IDLE) | i_tx_valid;

   // ---------------------------------------------------------------- RX path
   logic                 rx_meta_q, rx_sync_q;
   uart_state_e          rx_state_q, rx_state_d;
   logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
   logic [2:0]           rx_idx_q,   rx_idx_d;
   logic [DATA_BITS-1:0] rx_data_q,  rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 rx_busy_q,  rx_busy_d;
   logic                 rx_mid, rx_end;

   // The timer is held clear in IDLE and first counts 0 one cycle after the
   // falling edge was seen, so its mid strobe sits one count early to land
   // the sample C/2 cycles after that edge.
   uart_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .MID_CNT      (CLKS_PER_BIT / 2 - 1)
   ) u_rx_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (rx_state_q != IDLE),
      .o_mid (rx_mid),
      .o_end (rx_end)
   );

   // RX next state: detect start, verify at mid-start, sample data and stop at mid-bit
   always_comb begin
      rx_state_d = rx_state_q;
      rx_shift_d = rx_shift_q;
      rx_idx_d   = rx_idx_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      case (rx_state_q)
         IDLE: begin
            if (rx_sync_q == START_BIT) begin
               rx_state_d = START;
            end
         end
         START: begin
            if (rx_mid) begin
               if (rx_sync_q != START_BIT) begin
                  rx_state_d = IDLE;
               end else begin
                  rx_state_d = DATA;
                  rx_idx_d   = '0;
               end
            end
         end
         DATA: begin
            if (rx_mid) begin
               rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
               if (rx_idx_q == LAST_BIT) begin
                  rx_state_d = STOP;
               end else begin
                  rx_idx_d = rx_idx_q + 3'd1;
               end
            end
         end
         STOP: begin
            if (rx_mid) begin
               if (rx_sync_q == STOP_BIT) begin
                  rx_data_d  = rx_shift_q;
                  rx_valid_d = 1'b1;
               end
               rx_state_d = IDLE;
            end
         end
         default: begin
            rx_state_d = IDLE;
         end
      endcase
      rx_busy_d = (rx_state_d != IDLE);
   end

   // RX synchronizer, state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_state_q <= IDLE;
         rx_shift_q <= '0;
         rx_idx_q   <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_busy_q  <= 1'b0;
      end else begin
         rx_meta_q  <= i_rx_data;
         rx_sync_q  <= rx_meta_q;
         rx_state_q <= rx_state_d;
         rx_shift_q <= rx_shift_d;
         rx_idx_q   <= rx_idx_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rx_busy_q  <= rx_busy_d;
      end
   end

   assign o_rx_data  = rx_data_q;
   assign o_rx_valid = rx_valid_q;
   assign o_rx_busy  = rx_busy_q;

   logic unused_strobes;
   assign unused_strobes = tx_mid | rx_end;

endmodule

// File: tb/tb_uart_phy.sv
// Self-checking bench for uart_phy: a frame-timing model compared every
// cycle, directed checks with hand-derived values, and randomized traffic.
module tb_uart_phy;

   localparam int C = 4;

   logic       clk;
   logic       rst_n;
   logic       rx_line;
   logic       rx_drv;
   logic       loop_en;
   logic       o_rx_valid;
   logic       o_rx_busy;
   logic [7:0] o_rx_data;
   logic [7:0] i_tx_data;
   logic       i_tx_valid;
   logic       o_tx_busy;
   logic       o_tx_data;

   int nchk = 0;
   int nerr = 0;
   int rxv_cnt = 0;

   assign rx_line = loop_en ? o_tx_data : rx_drv;

   uart_phy #(.CLKS_PER_BIT(C)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_rx_data  (rx_line),
      .o_rx_valid (o_rx_valid),
      .o_rx_busy  (o_rx_busy),
      .o_rx_data  (o_rx_data),
      .i_tx_data  (i_tx_data),
      .i_tx_valid (i_tx_valid),
      .o_tx_busy  (o_tx_busy),
      .o_tx_data  (o_tx_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at time %0t", name, got, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------- model
   // TX: frame accepted at cycle a occupies cycles a+1 .. a+10C, bit i of the
   // 10-bit frame over cycles a+1+iC .. a+(i+1)C.
   // RX: the line seen by the receiver is the pin delayed two cycles; with
   // the falling edge seen at cycle f, bit j is sampled at f + C/2 + jC.
   initial begin
      int          cyc;
      bit          tx_act;
      int          tx_a;
      logic [9:0]  tx_frame;
      bit          tx_on;
      logic        exp_line;
      bit          rx_idle;
      int          rx_f;
      logic [7:0]  rx_bits;
      logic [7:0]  rx_dreg;
      bit          rx_vpend;
      logic        h1, h2, s;
      int          rel, k;
      cyc = 0; tx_act = 0; tx_a = 0; tx_frame = '1;
      rx_idle = 1; rx_f = 0; rx_bits = '0; rx_dreg = '0; rx_vpend = 0;
      h1 = 1'b1; h2 = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_tx_data", o_tx_data, 1);
            chk("rst_tx_busy", o_tx_busy, i_tx_valid);
            chk("rst_rx_valid", o_rx_valid, 0);
            chk("rst_rx_busy", o_rx_busy, 0);
            chk("rst_rx_data", o_rx_data, 0);
            tx_act = 0; rx_idle = 1; rx_vpend = 0; rx_dreg = '0;
            h1 = 1'b1; h2 = 1'b1;
         end else begin
            s        = h2;
            tx_on    = tx_act && (cyc <= tx_a + 10 * C);
            exp_line = tx_on ? tx_frame[(cyc - tx_a - 1) / C] : 1'b1;
            chk("tx_line", o_tx_data, exp_line);
            chk("tx_busy", o_tx_busy, tx_on || i_tx_valid);
            chk("rx_busy", o_rx_busy, !rx_idle);
            chk("rx_valid", o_rx_valid, rx_vpend);
            chk("rx_data", o_rx_data, rx_dreg);
            if (o_rx_valid) rxv_cnt++;
            if (!tx_on && i_tx_valid) begin
               tx_act   = 1;
               tx_a     = cyc;
               tx_frame = {1'b1, i_tx_data, 1'b0};
            end
            rx_vpend = 0;
            if (rx_idle) begin
               if (!s) begin
                  rx_idle = 0;
                  rx_f    = cyc;
               end
            end else begin
               rel = cyc - rx_f;
               if (rel == C / 2) begin
                  if (s) rx_idle = 1;
               end else if (rel > C / 2 && ((rel - C / 2) % C) == 0) begin
                  k = (rel - C / 2) / C;
                  if (k <= 8) begin
                     rx_bits[k-1] = s;
                  end else begin
                     if (s) begin
                        rx_dreg  = rx_bits;
                        rx_vpend = 1;
                     end
                     rx_idle = 1;
                  end
               end
            end
            h2 = h1;
            h1 = rx_line;
         end
         cyc++;
      end
   end

   // ---------------------------------------------------------------- helpers
   task automatic rx_frame(input logic [7:0] b, input logic stopb);
      logic [9:0] fr;
      fr = {stopb, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx_drv = fr[i];
         repeat (C) tick;
      end
      rx_drv = 1'b1;
   endtask

   task automatic tx_rand(input int n);
      for (int i = 0; i < n; i++) begin
         i_tx_valid = ($urandom_range(0, 5) == 0);
         i_tx_data  = 8'($urandom);
         tick;
      end
      i_tx_valid = 1'b0;
   endtask

   task automatic rx_rand(input int n);
      int r;
      for (int i = 0; i < n; i++) begin
         r = $urandom_range(0, 9);
         if (r == 0) begin
            rx_drv = 1'b0;
            repeat ($urandom_range(1, 3)) tick;
            rx_drv = 1'b1;
            repeat (C) tick;
         end else begin
            rx_frame(8'($urandom), r != 1);
         end
         repeat ($urandom_range(0, 4)) tick;
      end
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      logic [9:0] seq72;
      logic [7:0] lb [3];
      int         c0;
      bit         seen;
      seq72 = 10'b1_0111_0010_0;
      lb    = '{8'h00, 8'hFF, 8'h6E};

      rst_n = 1'b1; i_tx_valid = 1'b0; i_tx_data = '0; rx_drv = 1'b1; loop_en = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) tick;
      chk("reset_tx_data", o_tx_data, 1);
      chk("reset_tx_busy", o_tx_busy, 0);
      chk("reset_rx_valid", o_rx_valid, 0);
      chk("reset_rx_busy", o_rx_busy, 0);
      chk("reset_rx_data", o_rx_data, 0);
      rst_n = 1'b1;
      repeat (3) tick;

      // TX 0x72 with a second request one cycle later that must be ignored
      i_tx_data = 8'h72; i_tx_valid = 1'b1;
      #1 chk("tx72_busy_accept", o_tx_busy, 1);
      for (int j = 1; j <= 41; j++) begin
         tick;
         if (j == 1) i_tx_data = 8'hAA;
         if (j == 2) i_tx_valid = 1'b0;
         if (j <= 40) chk("tx72_line", o_tx_data, seq72[(j - 1) / 4]);
         if (j == 40) chk("tx72_busy_last", o_tx_busy, 1);
         if (j == 41) chk("tx72_busy_done", o_tx_busy, 0);
      end
      seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         tick;
         if (o_rx_valid) seen = 1;
      end
      chk("loop72_seen", seen, 1);
      chk("loop72_data", o_rx_data, 8'h72);
      repeat (3) tick;

      // Back-to-back "1","7": request held high across the frame boundary
      c0 = rxv_cnt;
      i_tx_data = 8'h31; i_tx_valid = 1'b1;
      for (int j = 1; j <= 46; j++) begin
         tick;
         if (j == 1) i_tx_data = 8'h37;
         if (j == 42) i_tx_valid = 1'b0;
         if (j == 40) chk("b2b_stop", o_tx_data, 1);
         if (j == 41) chk("b2b_idle_cycle", o_tx_data, 1);
         if (j == 42) chk("b2b_start", o_tx_data, 0);
         if (j == 45) chk("b2b_start_end", o_tx_data, 0);
         if (j == 46) chk("b2b_bit0", o_tx_data, 1);
      end
      repeat (60) tick;
      chk("b2b_rx_count", rxv_cnt - c0, 2);
      chk("b2b_rx_last", o_rx_data, 8'h37);

      // Loopback of boundary bytes
      c0 = rxv_cnt;
      for (int i = 0; i < 3; i++) begin
         i_tx_data = lb[i]; i_tx_valid = 1'b1;
         tick;
         i_tx_valid = 1'b0;
         repeat (10 * C + 8) tick;
         chk("loop_data", o_rx_data, lb[i]);
      end
      chk("loop_count", rxv_cnt - c0, 3);

      // Reset in the middle of a TX frame
      i_tx_data = 8'hC3; i_tx_valid = 1'b1;
      tick;
      i_tx_valid = 1'b0;
      repeat (15) tick;
      chk("pre_rst_line", o_tx_data, 0);
      #3 rst_n = 1'b0;
      #1;
      chk("mid_rst_tx_data", o_tx_data, 1);
      chk("mid_rst_tx_busy", o_tx_busy, 0);
      tick; tick;
      rst_n = 1'b1;
      repeat (4) tick;

      // Direct RX: one-cycle glitch
      loop_en = 1'b0; rx_drv = 1'b1;
      repeat (5) tick;
      c0 = rxv_cnt;
      rx_drv = 1'b0;
      tick;
      rx_drv = 1'b1;
      repeat (2) tick;
      chk("glitch_busy_high", o_rx_busy, 1);
      repeat (3) tick;
      chk("glitch_busy_low", o_rx_busy, 0);
      repeat (20) tick;
      chk("glitch_no_valid", rxv_cnt - c0, 0);

      // Direct RX: good frame, framing error, good frame
      c0 = rxv_cnt;
      rx_frame(8'hA5, 1'b1);
      repeat (4) tick;
      chk("frame_a5", o_rx_data, 8'hA5);
      rx_frame(8'h3C, 1'b0);
      repeat (12) tick;
      chk("ferr_hold", o_rx_data, 8'hA5);
      chk("ferr_count", rxv_cnt - c0, 1);
      rx_frame(8'h5A, 1'b1);
      repeat (4) tick;
      chk("frame_5a", o_rx_data, 8'h5A);
      chk("frame_count", rxv_cnt - c0, 2);

      // Randomized simultaneous TX and RX traffic
      fork
         tx_rand(1500);
         rx_rand(25);
      join
      repeat (20) tick;

      // Randomized loopback traffic
      loop_en = 1'b1;
      tx_rand(800);
      repeat (60) tick;

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #2000000;
      nerr++;
      $display("FAIL global_timeout: got running expected finished");
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $fatal(1, "timeout");
   end

endmodule
